usb_rx_packet_writer: RTL
=========================

USB_RX_PACKET_WRITER -- requirements
Module: usb_rx_packet_writer

Interface
REQ-001 SHALL expose parameter BUFFER_BYTES, default 1024, packet buffer capacity in bytes (multiple of 4).
REQ-002 SHALL expose ports: clk48  in  1  48 MHz system clock; rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL expose: bit_valid  in  1  one-cycle strobe per recovered 12 Mbps bit period; rx_j  in  1  line state J(1)/K(0) at strobe; rx_se0  in  1  SE0 at strobe (overrides rx_j).
REQ-004 SHALL expose: rx_enable  in  1  1 = buffer owned by receiver, packets may start.
REQ-005 SHALL expose: buf_wr_addr  out  8  word index; buf_wr_data  out  32  little-endian word (byte0 = [7:0]); buf_wr_sections  out  3  bit0 = [7:0], bit1 = [15:8], bit2 = [31:16].
REQ-006 SHALL expose: packet_ready  out  1  one-cycle done pulse; packet_length  out  11  received bytes; packet_error  out  1  qualifies packet_ready.

Function
REQ-007 SHALL act only on cycles with bit_valid=1; bit_valid spacing is >=2 cycles.
REQ-008 SHALL NRZI-decode: same level as previous bit -> 1, change -> 0; previous level resets to J.
REQ-009 SHALL implement states IDLE, SYNC, DATA, EOP, DROP.
REQ-010 IDLE -> SYNC on first K with rx_enable=1; K with rx_enable=0 -> DROP, packet silently ignored (no pulse).
REQ-011 SYNC: decoded 1 after >=3 decoded 0s -> DATA; decoded 1 after fewer -> DROP with error; SE0 -> IDLE, no pulse.
REQ-012 DATA: six consecutive decoded 1s -> next bit discarded; if it is 1, stuff error -> DROP.
REQ-013 DATA: data bits shift in LSB first; each 8th bit completes a byte.
REQ-014 Each 4th byte: SHALL write the full word, sections 111, on the cycle after the completing strobe; buf_wr_addr starts at 0 per packet and increments per write.
REQ-015 buf_wr_sections SHALL be 000 on all non-write cycles.
REQ-016 SE0 in DATA -> EOP; bit count not multiple of 8 -> error flagged.
REQ-017 EOP/DROP complete on first non-SE0 J strobe after SE0, then -> IDLE.
REQ-018 On completion: cycle+1 flushes partial word (1 byte -> 001, 2 -> 011, 3 -> 111, unused bytes 0); cycle+2 pulses packet_ready with length/error valid that cycle.
REQ-019 Bytes beyond BUFFER_BYTES SHALL not be written; length saturates at BUFFER_BYTES; error set.
REQ-020 DROP from error SHALL pulse packet_ready with error=1 at completion; length = whole bytes received.
REQ-021 rx_enable falling mid-packet SHALL NOT abort the current packet.
REQ-022 packet_length/packet_error SHALL hold until the next pulse.

Reset
REQ-023 rst SHALL force IDLE, NRZI level J, counters 0, all outputs 0, no write or pulse on the following cycle.
REQ-024 rst mid-packet SHALL abandon the packet with no further writes or pulse.

Structure
REQ-025 Shared package usb_pkg SHALL hold the state enum, USB_PACKET_BUFFER_SIZE, and section encodings.
REQ-026 NRZI decode plus bit unstuffing SHALL be sub-module usb_nrzi_unstuff (outputs data_bit, data_valid, stuff_error).

Verification
REQ-027 Sync + 0x2D 0x00 0x10 + EOP -> one write addr 0, data 0x0010002D, sections 111; ready at +2, length 3, error 0.
REQ-028 Sync + 0xFF with stuffed 0 after 6th one + EOP -> write addr 0, data 0x000000FF, sections 001; length 1, error 0.
REQ-029 Sync + seven decoded 1s unstuffed, then SE0/J -> no write, ready with error 1, length 0.
REQ-030 Sync + 1025 bytes 0xA5 + EOP -> 256 writes of 0xA5A5A5A5 addr 0..255, ready with length 1024, error 1.
REQ-031 Sync + 12 data bits + EOP -> flush 001, length 1, error 1; rst during 2nd byte of next packet -> no write/pulse, following packet 0x2D 0x00 0x10 received per REQ-027.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed receive path: receiver states,
// buffer sizing and byte-lane write-enable encodings.
package usb_pkg;

  localparam int unsigned USB_PACKET_BUFFER_SIZE = 1024;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    DROP
  } rx_state_t;

  localparam logic [2:0] SECT_NONE  = 3'b000;
  localparam logic [2:0] SECT_BYTE0 = 3'b001;
  localparam logic [2:0] SECT_HALF  = 3'b011;
  localparam logic [2:0] SECT_WORD  = 3'b111;

  // Lane enables for a trailing word holding 'nbytes' valid bytes.
  function automatic logic [2:0] flush_sections(input logic [1:0] nbytes);
    case (nbytes)
      2'd1:    return SECT_BYTE0;
      2'd2:    return SECT_HALF;
      2'd3:    return SECT_WORD;
      default: return SECT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder with bit unstuffing; decode results are combinational on the
// strobe cycle so the packet FSM can act on the same edge.
module usb_nrzi_unstuff (
  input  logic clk48,
  input  logic rst,
  input  logic bit_valid,
  input  logic rx_j,
  input  logic rx_se0,
  input  logic unstuff_en,
  output logic data_bit,
  output logic data_valid,
  output logic stuff_error
);

  logic       prev_j;
  logic [2:0] ones;
  logic       live;
  logic       stuff_slot;

  always_comb begin
    live        = bit_valid && !rx_se0;
    stuff_slot  = unstuff_en && (ones == 3'd6);
    data_bit    = (rx_j == prev_j);
    data_valid  = live && !stuff_slot;
    stuff_error = live && stuff_slot && data_bit;
  end

  // SE0 returns the reference level to J so the next packet decodes from idle.
  always_ff @(posedge clk48) begin
    if (rst) begin
      prev_j <= 1'b1;
      ones   <= '0;
    end else if (bit_valid) begin
      if (rx_se0) begin
        prev_j <= 1'b1;
        ones   <= '0;
      end else begin
        prev_j <= rx_j;
        if (!unstuff_en || stuff_slot || !data_bit) begin
          ones <= '0;
        end else begin
          ones <= ones + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_rx_packet_writer.sv
// USB full-speed packet receiver: sync detection, byte assembly and
// little-endian word writes into a packet buffer, with a done pulse.
module usb_rx_packet_writer #(
  parameter int unsigned BUFFER_BYTES = usb_pkg::USB_PACKET_BUFFER_SIZE
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        rx_j,
  input  logic        rx_se0,
  input  logic        rx_enable,
  output logic [7:0]  buf_wr_addr,
  output logic [31:0] buf_wr_data,
  output logic [2:0]  buf_wr_sections,
  output logic        packet_ready,
  output logic [10:0] packet_length,
  output logic        packet_error
);
  import usb_pkg::*;

  localparam logic [10:0] CAP = 11'(BUFFER_BYTES);

  rx_state_t   state;
  logic [1:0]  sync_zeros;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic [23:0] word;
  logic [10:0] byte_cnt;
  logic        pkt_err;
  logic        report;
  logic        drop_se0;
  logic        ready_pend;

  logic        data_bit;
  logic        data_valid;
  logic        stuff_error;
  logic [7:0]  new_byte;
  logic        finish;
  logic        do_report;

  usb_nrzi_unstuff u_nrzi (
    .clk48       (clk48),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .rx_j        (rx_j),
    .rx_se0      (rx_se0),
    .unstuff_en  (state == DATA),
    .data_bit    (data_bit),
    .data_valid  (data_valid),
    .stuff_error (stuff_error)
  );

  always_comb begin
    new_byte  = {data_bit, shift};
    finish    = bit_valid && !rx_se0 && rx_j &&
                ((state == EOP) || ((state == DROP) && drop_se0));
    do_report = (state == EOP) || report;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state           <= IDLE;
      sync_zeros      <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      word            <= '0;
      byte_cnt        <= '0;
      pkt_err         <= 1'b0;
      report          <= 1'b0;
      drop_se0        <= 1'b0;
      ready_pend      <= 1'b0;
      buf_wr_addr     <= '0;
      buf_wr_data     <= '0;
      buf_wr_sections <= SECT_NONE;
      packet_ready    <= 1'b0;
      packet_length   <= '0;
      packet_error    <= 1'b0;
    end else begin
      buf_wr_sections <= SECT_NONE;
      packet_ready    <= 1'b0;
      ready_pend      <= 1'b0;

      if (ready_pend) begin
        packet_ready  <= 1'b1;
        packet_length <= byte_cnt;
        packet_error  <= pkt_err;
      end

      if (finish) begin
        state <= IDLE;
        if (do_report) begin
          ready_pend <= 1'b1;
          if (byte_cnt[1:0] != 2'd0) begin
            buf_wr_addr     <= byte_cnt[9:2];
            buf_wr_data     <= {8'h00, word};
            buf_wr_sections <= flush_sections(byte_cnt[1:0]);
          end
        end
      end else if (bit_valid) begin
        unique case (state)
          IDLE: begin
            if (!rx_se0 && !rx_j) begin
              if (rx_enable) begin
                state      <= SYNC;
                sync_zeros <= 2'd1;
                bit_cnt    <= '0;
                byte_cnt   <= '0;
                word       <= '0;
                pkt_err    <= 1'b0;
              end else begin
                state    <= DROP;
                report   <= 1'b0;
                drop_se0 <= 1'b0;
              end
            end
          end
          SYNC: begin
            if (rx_se0) begin
              state <= IDLE;
            end else if (data_bit) begin
              if (sync_zeros == 2'd3) begin
                state <= DATA;
              end else begin
                state    <= DROP;
                report   <= 1'b1;
                drop_se0 <= 1'b0;
                pkt_err  <= 1'b1;
              end
            end else if (sync_zeros != 2'd3) begin
              sync_zeros <= sync_zeros + 2'd1;
            end
          end
          DATA: begin
            if (rx_se0) begin
              state <= EOP;
              if (bit_cnt != 3'd0) pkt_err <= 1'b1;
            end else if (stuff_error) begin
              state    <= DROP;
              report   <= 1'b1;
              drop_se0 <= 1'b0;
              pkt_err  <= 1'b1;
            end else if (data_valid) begin
              shift   <= new_byte[7:1];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // Bytes past capacity are dropped but keep the packet alive.
                if (byte_cnt == CAP) begin
                  pkt_err <= 1'b1;
                end else begin
                  byte_cnt <= byte_cnt + 11'd1;
                  unique case (byte_cnt[1:0])
                    2'd0: word[7:0]   <= new_byte;
                    2'd1: word[15:8]  <= new_byte;
                    2'd2: word[23:16] <= new_byte;
                    default: begin
                      buf_wr_addr     <= byte_cnt[9:2];
                      buf_wr_data     <= {new_byte, word};
                      buf_wr_sections <= SECT_WORD;
                      word            <= '0;
                    end
                  endcase
                end
              end
            end
          end
          EOP: begin
          end
          DROP: begin
            if (rx_se0) drop_se0 <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
